// File: rtl/access_pkg.sv
// access_pkg: shared state encoding, widths and helpers for the password interface
package access_pkg;

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        LOAD,
        WAIT_STATUS,
        GRANTED,
        DENIED,
        LOCKED
    } state_t;

    localparam int GRANT_BIT  = 0;
    localparam int PASSWORD_W = 16;
    localparam int DIGIT_W    = 4;
    localparam int NUM_DIGITS = 4;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/cycle_timer.sv
// cycle_timer: loadable down-counter whose done pulse fires once when it reaches zero
module cycle_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         done
);

    logic [W-1:0] count;
    logic         armed;

    // count down from the loaded value, holding at zero and disarming after the pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            armed <= 1'b0;
        end else if (load) begin
            count <= value;
            armed <= 1'b1;
        end else if (armed) begin
            armed <= (count != '0);
            count <= (count == '0) ? count : count - 1'b1;
        end
    end

    assign done = armed && (count == '0);

endmodule

// File: rtl/password_entry.sv
// password_entry: collects four keypad digits, presents the packed word and tracks grant/deny/lockout
module password_entry
    import access_pkg::*;
#(
    parameter int STATUS_WAIT = 3,
    parameter int HOLD_CYCLES = 8,
    parameter int MAX_FAIL    = 3,
    parameter int LOCK_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DIGIT_W-1:0]    _Digit,
    input  logic                  _Digit_Load,
    input  logic [1:0]            _Mode,
    input  logic [2:0]            _Status_Frame,
    output logic [1:0]            _Request,
    output logic [PASSWORD_W-1:0] _Data_Out,
    output logic                  _Data_Out_Load,
    output logic                  Access_Granted,
    output logic                  Access_Denied,
    output logic                  Locked
);

    // one timer serves the wait, hold and lock intervals, so it is sized for the longest
    localparam int TW = max_int(4, max_int($clog2(HOLD_CYCLES), $clog2(LOCK_CYCLES)));

    state_t       state, next_state;
    logic [2:0]   digit_count;
    logic [2:0]   fail_count;
    logic [2:0]   fail_next;
    logic         grant;
    logic         timer_load;
    logic [TW-1:0] timer_value;
    logic         timer_done;
    logic         accept;
    logic         unused;

    assign unused    = ^_Status_Frame[2:1];
    assign grant     = _Status_Frame[GRANT_BIT];
    assign accept    = _Digit_Load && (state == IDLE || state == COLLECT);
    assign fail_next = (fail_count >= 3'(MAX_FAIL)) ? fail_count : fail_count + 3'd1;

    // state register
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= next_state;
    end

    // next-state decision
    always_comb begin
        next_state = state;
        case (state)
            IDLE:        next_state = _Digit_Load ? COLLECT : IDLE;
            COLLECT:     next_state = (_Digit_Load && digit_count == 3'(NUM_DIGITS - 1)) ? LOAD : COLLECT;
            LOAD:        next_state = WAIT_STATUS;
            WAIT_STATUS: next_state = !timer_done ? WAIT_STATUS :
                                      grant ? GRANTED :
                                      (fail_next == 3'(MAX_FAIL)) ? LOCKED : DENIED;
            GRANTED,
            DENIED,
            LOCKED:      next_state = timer_done ? IDLE : state;
            default:     next_state = IDLE;
        endcase
    end

    // reload the timer whenever a timed state is entered
    always_comb begin
        timer_load  = (next_state != state) &&
                      (next_state == WAIT_STATUS || next_state == GRANTED ||
                       next_state == DENIED || next_state == LOCKED);
        timer_value = (next_state == WAIT_STATUS) ? TW'(STATUS_WAIT - 1) :
                      (next_state == LOCKED)      ? TW'(LOCK_CYCLES - 1) : TW'(HOLD_CYCLES - 1);
    end

    cycle_timer #(.W(TW)) u_timer (
        .clk   (clk),
        .rst   (rst),
        .load  (timer_load),
        .value (timer_value),
        .done  (timer_done)
    );

    // digit shift register, request latch and consecutive-failure counter
    always_ff @(posedge clk) begin
        if (rst) begin
            _Data_Out   <= '0;
            _Request    <= 2'b00;
            digit_count <= 3'd0;
            fail_count  <= 3'd0;
        end else begin
            if (accept) begin
                _Data_Out   <= {_Data_Out[PASSWORD_W-DIGIT_W-1:0], _Digit};
                _Request    <= (state == IDLE) ? _Mode : _Request;
                digit_count <= (state == IDLE) ? 3'd1 : digit_count + 3'd1;
            end
            if (state == WAIT_STATUS && timer_done)
                fail_count <= grant ? 3'd0 : fail_next;
            if ((state == GRANTED || state == DENIED || state == LOCKED) && timer_done) begin
                _Data_Out  <= '0;
                fail_count <= (state == LOCKED) ? 3'd0 : fail_count;
            end
        end
    end

    // Moore outputs decoded from the state register
    always_comb begin
        _Data_Out_Load = (state == LOAD);
        Access_Granted = (state == GRANTED);
        Access_Denied  = (state == DENIED);
        Locked         = (state == LOCKED);
    end

endmodule
